// File: rtl/clk_div_pkg.sv
// Shared definitions for the clk_div clock divider: default sizing and a
// helper that returns the counter width needed for a given terminal count.
package clk_div_pkg;

    localparam int CLK_DIV_COUNT_WIDTH_DEF = 24;
    localparam int CLK_DIV_MAX_COUNT_DEF   = 1_500_000 - 1;

    // Minimum number of bits able to hold max_val (at least 1).
    function automatic int clk_div_width(input int unsigned max_val);
        int w;
        w = 1;
        for (int i = 1; i < 32; i++) begin
            if ((max_val >> i) != 0) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/clk_div_counter.sv
// Modulo-(MAX_COUNT+1) counter with asynchronous active-high reset and a
// combinational terminal-count strobe. Wraps only through the compare.
module clk_div_counter
    import clk_div_pkg::*;
#(
    parameter int COUNT_WIDTH = CLK_DIV_COUNT_WIDTH_DEF,
    parameter int MAX_COUNT   = CLK_DIV_MAX_COUNT_DEF
) (
    input  logic clk,
    input  logic rst,
    output logic tc
);

    // Refuse to build a counter that cannot reach its terminal value.
    if (COUNT_WIDTH < 1) begin : g_bad_width
        $error("clk_div_counter: COUNT_WIDTH must be at least 1");
    end
    if (clk_div_width(MAX_COUNT) > COUNT_WIDTH) begin : g_bad_max
        $error("clk_div_counter: MAX_COUNT does not fit in COUNT_WIDTH bits");
    end

    localparam logic [COUNT_WIDTH-1:0] TERM = COUNT_WIDTH'(MAX_COUNT);

    logic [COUNT_WIDTH-1:0] count;

    assign tc = (count == TERM);

    // Count up, returning to zero on the terminal count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (tc) begin
            count <= '0;
        end else begin
            count <= count + COUNT_WIDTH'(1);
        end
    end

endmodule

// File: rtl/clk_div.sv
// Clock divider top: square-wave output toggling every MAX_COUNT+1 clocks,
// period 2*(MAX_COUNT+1). Optional feature macro CLK_DIV_TICK_EN adds a
// registered one-cycle 'tick' pulse coincident with each 'out' toggle.
module clk_div
    import clk_div_pkg::*;
#(
    parameter int COUNT_WIDTH = CLK_DIV_COUNT_WIDTH_DEF,
    parameter int MAX_COUNT   = CLK_DIV_MAX_COUNT_DEF
) (
    input  logic clk,
    input  logic rst,
    output logic out
`ifdef CLK_DIV_TICK_EN
    ,
    output logic tick
`endif
);

    logic tc;

    clk_div_counter #(
        .COUNT_WIDTH (COUNT_WIDTH),
        .MAX_COUNT   (MAX_COUNT)
    ) u_counter (
        .clk (clk),
        .rst (rst),
        .tc  (tc)
    );

    // Toggle the divided output each time the counter reaches terminal count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out <= 1'b0;
        end else if (tc) begin
            out <= ~out;
        end
    end

`ifdef CLK_DIV_TICK_EN
    // Register the terminal-count strobe so it lines up with the out toggle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick <= 1'b0;
        end else begin
            tick <= tc;
        end
    end
`endif

endmodule

// File: tb/tb_clk_div.sv
// Bench for clk_div: three instances (divide-by-12, divide-by-2, full-range
// divide-by-32) share clock and random 1 ns asynchronous reset pulses.
`timescale 1ns/1ps
module tb_clk_div;

    logic clk;
    logic rst;
    logic out5, out0, out15;
`ifdef CLK_DIV_TICK_EN
    logic tick5, tick0, tick15;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic       o5;
        logic [3:0] c5;
        logic       o0;
        logic       o15;
        logic [3:0] c15;
        logic       t5;
    } exp_t;

    exp_t q[$];

    clk_div #(.COUNT_WIDTH(4), .MAX_COUNT(5)) dut5 (
        .clk (clk), .rst (rst), .out (out5)
`ifdef CLK_DIV_TICK_EN
        , .tick (tick5)
`endif
    );

    clk_div #(.COUNT_WIDTH(1), .MAX_COUNT(0)) dut0 (
        .clk (clk), .rst (rst), .out (out0)
`ifdef CLK_DIV_TICK_EN
        , .tick (tick0)
`endif
    );

    clk_div #(.COUNT_WIDTH(4), .MAX_COUNT(15)) dut15 (
        .clk (clk), .rst (rst), .out (out15)
`ifdef CLK_DIV_TICK_EN
        , .tick (tick15)
`endif
    );

    initial clk = 1'b0;
    always #41.667 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: after n rising edges since reset release with
    // terminal count m, the counter holds n mod (m+1) and out has toggled
    // floor(n/(m+1)) times.
    function automatic exp_t model(input int n);
        exp_t e;
        e.o5  = ((n / 6) % 2) == 1;
        e.c5  = 4'(n % 6);
        e.o0  = (n % 2) == 1;
        e.o15 = ((n / 16) % 2) == 1;
        e.c15 = 4'(n % 16);
        e.t5  = (n > 0) && (n % 6 == 0);
        return e;
    endfunction

    task automatic check_zero(input string tag);
        chk({tag, "_out5"}, {31'd0, out5}, 32'd0);
        chk({tag, "_cnt5"}, {28'd0, dut5.u_counter.count}, 32'd0);
        chk({tag, "_out0"}, {31'd0, out0}, 32'd0);
        chk({tag, "_out15"}, {31'd0, out15}, 32'd0);
`ifdef CLK_DIV_TICK_EN
        chk({tag, "_tick5"}, {31'd0, tick5}, 32'd0);
`endif
    endtask

    // Monitor: one expected entry per cycle, compared on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("out5", {31'd0, out5}, {31'd0, e.o5});
            chk("count5", {28'd0, dut5.u_counter.count}, {28'd0, e.c5});
            chk("out0", {31'd0, out0}, {31'd0, e.o0});
            chk("out15", {31'd0, out15}, {31'd0, e.o15});
            chk("count15", {28'd0, dut15.u_counter.count}, {28'd0, e.c15});
`ifdef CLK_DIV_TICK_EN
            chk("tick5", {31'd0, tick5}, {31'd0, e.t5});
`endif
        end
    end

    // Driver: advances the edge count, injects reset pulses, pushes expectations.
    initial begin
        int  n;
        bit  did_mid_reset;
        bit  do_rst;
        int  off;
        rst = 1'b0;
        n = 0;
        did_mid_reset = 1'b0;

        #10;
        rst = 1'b1;
        #0.5;
        check_zero("por");
        #0.5;
        rst = 1'b0;

        for (int cyc = 0; cyc < 800; cyc++) begin
            @(posedge clk);
            n++;
            do_rst = 1'b0;
            if (!did_mid_reset && cyc > 40 && (n % 6) == 3 && ((n / 6) % 2) == 1) begin
                do_rst = 1'b1;
                did_mid_reset = 1'b1;
            end else if (cyc > 60 && $urandom_range(0, 39) == 0) begin
                do_rst = 1'b1;
            end
            off = $urandom_range(5, 28);
            #(off);
            if (do_rst) begin
                rst = 1'b1;
                #0.5;
                check_zero("async_rst");
                #0.5;
                rst = 1'b0;
                n = 0;
            end
            q.push_back(model(n));
        end

        @(posedge clk);
        @(negedge clk);
        #1;
        chk("queue_drained", q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/clk_div.md
# clk_div

Parameterizable synchronous clock divider: a free-running counter toggles a registered square-wave output every `MAX_COUNT+1` input clock cycles. The output period is therefore `2*(MAX_COUNT+1)` input cycles. It sits between the board oscillator domain (for example, 12 MHz) and slow logic such as LED blinkers or strobe generators. The output is a logic signal and is not routed onto a global clock net.

## Interface
- `COUNT_WIDTH`, default 24: counter width in bits.
- `MAX_COUNT`, default 1_500_000-1: terminal count; the output toggles every `MAX_COUNT+1` cycles.
- `clk`, input, 1: sole clock; all state updates on its rising edge.
- `rst`, input, 1: one clock; reset is asynchronous and active-high.
- `out`, output, 1: divided output, driven directly from a flop.
- `tick`, output, 1: present only with `CLK_DIV_TICK_EN` (see Configuration).

## Operation
- State:
  - `count[COUNT_WIDTH-1:0]`
  - `out` register
- Reset: while `rst`=1, `count`=0 and `out`=0 (and `tick`=0). Reset takes effect immediately, independent of `clk`.
- Each rising edge with `rst`=0:
  - If `count == MAX_COUNT`: `count` <= 0 and `out` <= ~`out`.
  - Otherwise: `count` <= `count`+1.
- Counter arithmetic is unsigned and wraps to 0 only via the terminal-count compare, never via natural overflow.
- `MAX_COUNT`=0: `out` toggles every cycle, giving divide-by-2.
- Elaboration must fail (generate-time `$error`) if `MAX_COUNT` ≥ 2^`COUNT_WIDTH` or `COUNT_WIDTH` < 1.
- Reset mid-period: the phase is discarded; after release the first toggle occurs `MAX_COUNT+1` edges later.

## Timing
- Latency from reset release to the first `out` rise: `MAX_COUNT+1` rising edges. With `MAX_COUNT`=5, `out` rises on the 6th edge.
- Steady state:
  - `out` high for exactly `MAX_COUNT+1` cycles, then low for `MAX_COUNT+1` cycles (50% duty).
  - Output frequency = f_clk / (2*(`MAX_COUNT`+1)).
- `out` changes only on a rising `clk` edge, or asynchronously on `rst` assertion.
- `rst` asserted for less than one clock period (for example, a 1 ns pulse) must still fully reset the state.

## Configuration
- `CLK_DIV_TICK_EN` defined:
  - Adds output `tick`, registered.
  - `tick` = 1 for exactly one cycle coincident with each `out` toggle, i.e. the cycle after `count` was `MAX_COUNT`.
  - `tick` resets to 0.
- `CLK_DIV_TICK_EN` undefined: the `tick` port and its flop do not exist; `out` behaviour is identical in both builds.

## Structure
- Shared package `clk_div_pkg`:
  - function `clk_div_width(max)` returning the minimum counter width for a given terminal count.
  - localparam defaults for `COUNT_WIDTH`/`MAX_COUNT`.
- Sub-module `clk_div_counter`: a modulo-(`MAX_COUNT`+1) counter with async reset and a terminal-count strobe `tc`.
- Top level: instantiates `clk_div_counter` and holds the `out` toggle flop and the optional `tick` flop.

## Test plan
- `COUNT_WIDTH`=4, `MAX_COUNT`=5, clk half-period 41.667 ns, 1 ns `rst` pulse at 10 ns, run 10 µs:
  - `out`=0 during and after reset.
  - Period 12 clocks (≈1000 ns), 6 high / 6 low.
  - No X after reset.
- Same configuration: first `out` rise on the 6th rising edge after `rst` falls; `count` sequence 1,2,3,4,5,0.
- `MAX_COUNT`=0: `out` toggles on every rising edge (period 2 clocks).
- Assert `rst` when `count`=3 with `out`=1:
  - `out` and `count` clear to 0 immediately, before the next edge.
  - Next toggle occurs 6 edges after release.
- `MAX_COUNT`=15, `COUNT_WIDTH`=4 (full range): period 32 clocks with no premature wrap. `MAX_COUNT`=16 with `COUNT_WIDTH`=4 fails elaboration.
- With `CLK_DIV_TICK_EN`, `MAX_COUNT`=5: `tick` is a single-cycle pulse every 6 clocks, aligned with each `out` edge; `tick`=0 in reset.
